// File: rtl/data_mem_interface_v2.sv
// CPU-to-data-memory bridge: registers each load/store, screens it against the
// DMBottom/DMTop window and natural alignment, runs the memory handshake while
// stalling the CPU, and returns sized, extended load data. Rejected or
// timed-out accesses raise a one-cycle fault with a cause code.
module data_mem_interface_v2 #(
  parameter int unsigned DATA_W         = 64,
  parameter int unsigned ADDR_W         = 64,
  parameter int unsigned ALIGN_CHECK    = 1,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address_from_cpu,
  input  logic              read_bit_from_cpu,
  input  logic              write_bit_from_cpu,
  input  logic [1:0]        size_select_from_cpu,
  input  logic              sign_extend_from_cpu,
  input  logic [DATA_W-1:0] write_data_from_cpu,
  input  logic [ADDR_W-1:0] DMBottom,
  input  logic [ADDR_W-1:0] DMTop,
  output logic              stall_to_cpu,
  output logic [DATA_W-1:0] read_data_to_cpu,
  output logic              fault_to_cpu,
  output logic [2:0]        fault_code_to_cpu,
  output logic [ADDR_W-1:0] address_to_mem,
  output logic              read_request_to_mem,
  output logic              write_request_to_mem,
  output logic [1:0]        size_select_to_mem,
  output logic [DATA_W-1:0] write_data_to_mem,
  input  logic [DATA_W-1:0] read_data_from_mem,
  input  logic              read_ready_from_mem,
  input  logic              write_ready_from_mem,
  input  logic              write_finished_from_mem
);

  localparam int unsigned NB      = DATA_W / 8;
  // Last wait-cycle index before the timeout fires.
  localparam int unsigned TO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam int unsigned CNT_W   = (TO_LAST > 0) ? $clog2(TO_LAST + 1) : 1;

  typedef enum logic [2:0] {StIdle, StRdWait, StWrWaitReady, StWrWaitDone, StDone} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          size_q, size_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                sext_q, sext_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                fault_q, fault_d;
  logic [2:0]          code_q, code_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [3:0]          req_nbytes, req_nm1, cap_nbytes;
  logic [ADDR_W:0]     req_end;
  logic [2:0]          req_code;
  logic [DATA_W-1:0]   masked_wdata, load_ext;
  logic                load_sign, timed_out;

  function automatic logic [3:0] size_bytes(input logic [1:0] s);
    case (s)
      2'b10:   return 4'd1;
      2'b01:   return 4'd2;
      2'b00:   return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

  assign req_nbytes = size_bytes(size_select_from_cpu);
  assign req_nm1    = req_nbytes - 4'd1;
  assign cap_nbytes = size_bytes(size_q);
  // One extra bit so the last byte address cannot wrap past zero.
  assign req_end    = (ADDR_W+1)'(address_from_cpu) + (ADDR_W+1)'(req_nm1);
  assign timed_out  = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TO_LAST));

  // Legality screen of the incoming request, highest-priority cause first.
  always_comb begin
    req_code = 3'b000;
    if (read_bit_from_cpu && write_bit_from_cpu) begin
      req_code = 3'b011;
    end else if ((size_select_from_cpu == 2'b11) && (DATA_W == 32)) begin
      req_code = 3'b101;
    end else if ((address_from_cpu < DMBottom) || (req_end > {1'b0, DMTop})) begin
      req_code = 3'b001;
    end else if ((ALIGN_CHECK != 0) && ((address_from_cpu[2:0] & req_nm1[2:0]) != 3'b000)) begin
      req_code = 3'b010;
    end
  end

  // Store data with every byte beyond the access size forced to zero.
  always_comb begin
    masked_wdata = '0;
    for (int b = 0; b < NB; b++) begin
      if (b < int'(req_nbytes)) masked_wdata[8*b +: 8] = write_data_from_cpu[8*b +: 8];
    end
  end

  // Keep the low N bytes of the memory word and extend from the top kept bit.
  always_comb begin
    load_sign = 1'b0;
    load_ext  = '0;
    for (int b = 0; b < NB; b++) begin
      if (b < int'(cap_nbytes)) begin
        load_ext[8*b +: 8] = read_data_from_mem[8*b +: 8];
        load_sign          = read_data_from_mem[8*b + 7];
      end else begin
        load_ext[8*b +: 8] = {8{sext_q & load_sign}};
      end
    end
  end

  // Next-state, capture and stall decode.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    size_d       = size_q;
    wdata_d      = wdata_q;
    sext_d       = sext_q;
    rdata_d      = rdata_q;
    fault_d      = 1'b0;
    code_d       = 3'b000;
    cnt_d        = cnt_q + CNT_W'(1);
    stall_to_cpu = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (read_bit_from_cpu || write_bit_from_cpu) begin
          if (req_code != 3'b000) begin
            fault_d = 1'b1;
            code_d  = req_code;
          end else begin
            stall_to_cpu = 1'b1;
            addr_d       = address_from_cpu;
            size_d       = size_select_from_cpu;
            wdata_d      = masked_wdata;
            sext_d       = sign_extend_from_cpu;
            state_d      = read_bit_from_cpu ? StRdWait : StWrWaitReady;
          end
        end
      end
      StRdWait: begin
        stall_to_cpu = 1'b1;
        if (read_ready_from_mem) begin
          rdata_d = load_ext;
          state_d = StDone;
        end else if (timed_out) begin
          fault_d = 1'b1;
          code_d  = 3'b100;
          state_d = StIdle;
        end
      end
      StWrWaitReady: begin
        stall_to_cpu = 1'b1;
        if (write_ready_from_mem) begin
          cnt_d   = '0;
          state_d = StWrWaitDone;
        end else if (timed_out) begin
          fault_d = 1'b1;
          code_d  = 3'b100;
          state_d = StIdle;
        end
      end
      StWrWaitDone: begin
        stall_to_cpu = 1'b1;
        if (write_finished_from_mem) begin
          state_d = StDone;
        end else if (timed_out) begin
          fault_d = 1'b1;
          code_d  = 3'b100;
          state_d = StIdle;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and captured-access registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      size_q  <= '0;
      wdata_q <= '0;
      sext_q  <= 1'b0;
      rdata_q <= '0;
      fault_q <= 1'b0;
      code_q  <= 3'b000;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      wdata_q <= wdata_d;
      sext_q  <= sext_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
    end
  end

  assign read_request_to_mem  = (state_q == StRdWait);
  assign write_request_to_mem = (state_q == StWrWaitDone);
  assign address_to_mem       = addr_q;
  assign size_select_to_mem   = size_q;
  assign write_data_to_mem    = wdata_q;
  assign read_data_to_cpu     = rdata_q;
  assign fault_to_cpu         = fault_q;
  assign fault_code_to_cpu    = code_q;

endmodule
